// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HOLD   = 2'd2,
        SQUASH = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSN = 32'h0;

endpackage

// File: rtl/fetch_hold_reg.sv
// Hold register: keeps the instruction shown to F/D stable while downstream stalls.
module fetch_hold_reg
    import fetch_pkg::*;
#(
    parameter int PC_W   = 12,
    parameter int INSN_W = 32
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              load,
    input  logic [INSN_W-1:0] insn,
    input  logic [PC_W-1:0]   pc_plus,
    input  logic              valid,
    output logic [INSN_W-1:0] hold_insn,
    output logic [PC_W-1:0]   hold_pc_plus,
    output logic              hold_valid
);

    // Capture the live output on load; async clear empties the register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            hold_insn    <= '0;
            hold_pc_plus <= '0;
            hold_valid   <= 1'b0;
        end else if (load) begin
            hold_insn    <= insn;
            hold_pc_plus <= pc_plus;
            hold_valid   <= valid;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, feeds the F/D latch.
//
// state  | meaning
// BOOT   | first cycle after reset, no data returned yet, emit bubble
// RUN    | imem data is live and forwarded to F/D
// HOLD   | downstream stalled, replay the captured instruction
// SQUASH | wrong-path word returning after a redirect, emit bubble
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 12,
    parameter int              INSN_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_stall,
    input  logic              i_redirect,
    input  logic [PC_W-1:0]   i_redirect_target,
    input  logic [INSN_W-1:0] i_imem_data,
    output logic [PC_W-1:0]   o_imem_addr,
    output logic [INSN_W-1:0] o_insn,
    output logic [PC_W-1:0]   o_PC_plus,
    output logic              o_valid
);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   inflight_pc_q;
    logic [PC_W-1:0]   pc_inc;
    logic [PC_W-1:0]   live_pc_plus;
    logic              hold_load;
    logic [INSN_W-1:0] hold_insn_q;
    logic [PC_W-1:0]   hold_pcp_q;
    logic              hold_valid_q;

    // Address wraps modulo 2^PC_W; the returned word's PC+1 wraps the same way.
    assign pc_inc       = pc_q + PC_W'(1);
    assign live_pc_plus = inflight_pc_q + PC_W'(1);
    assign o_imem_addr  = pc_q;

    fetch_hold_reg #(
        .PC_W   (PC_W),
        .INSN_W (INSN_W)
    ) u_hold (
        .clock        (clock),
        .clear_n      (reset),
        .load         (hold_load),
        .insn         (i_imem_data),
        .pc_plus      (live_pc_plus),
        .valid        (1'b1),
        .hold_insn    (hold_insn_q),
        .hold_pc_plus (hold_pcp_q),
        .hold_valid   (hold_valid_q)
    );

    // Next state, next PC and the F/D output selection.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        hold_load = 1'b0;
        o_insn    = INSN_W'(NOP_INSN);
        o_PC_plus = '0;
        o_valid   = 1'b0;
        case (state_q)
            BOOT, SQUASH: begin
                if (!i_stall) pc_d = pc_inc;
                state_d = RUN;
            end
            RUN: begin
                o_insn    = i_imem_data;
                o_PC_plus = live_pc_plus;
                o_valid   = 1'b1;
                if (!i_stall) begin
                    pc_d = pc_inc;
                end else begin
                    hold_load = 1'b1;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                o_insn    = hold_insn_q;
                o_PC_plus = hold_pcp_q;
                o_valid   = hold_valid_q;
                if (!i_stall) begin
                    pc_d    = pc_inc;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        // A redirect beats a stall; the word already in flight is wrong-path.
        if (i_redirect) begin
            pc_d      = i_redirect_target;
            state_d   = SQUASH;
            hold_load = 1'b0;
        end
    end

    // State, PC and in-flight address registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            inflight_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a behavioural model.
module tb_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [11:0] i_redirect_target = '0;
    logic [31:0] i_imem_data = '0;
    logic [11:0] o_imem_addr;
    logic [31:0] o_insn;
    logic [11:0] o_PC_plus;
    logic        o_valid;

    logic [31:0] mem [0:4095];

    int checks = 0;
    int errors = 0;

    // Behavioural model: what F/D should see, as derived from the fetch rules.
    int          m_mode;      // 0 bubble cycle, 1 live, 2 replaying held word
    logic [11:0] m_pc;
    logic [11:0] m_inflight;
    logic [31:0] m_held_insn;
    logic [11:0] m_held_pcp;

    fetch_stage dut (
        .clock             (clock),
        .reset             (reset),
        .i_stall           (i_stall),
        .i_redirect        (i_redirect),
        .i_redirect_target (i_redirect_target),
        .i_imem_data       (i_imem_data),
        .o_imem_addr       (o_imem_addr),
        .o_insn            (o_insn),
        .o_PC_plus         (o_PC_plus),
        .o_valid           (o_valid)
    );

    always #5 clock = ~clock;

    // Synchronous instruction memory: data for the address one cycle later.
    always @(posedge clock) i_imem_data <= mem[o_imem_addr];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode      = 0;
        m_pc        = 12'h000;
        m_inflight  = 12'h000;
        m_held_insn = '0;
        m_held_pcp  = '0;
    endtask

    task automatic model_out(output logic [31:0] insn, output logic [11:0] pcp, output logic v);
        if (m_mode == 0) begin
            insn = 32'h0; pcp = 12'h0; v = 1'b0;
        end else if (m_mode == 1) begin
            insn = mem[m_inflight]; pcp = m_inflight + 12'd1; v = 1'b1;
        end else begin
            insn = m_held_insn; pcp = m_held_pcp; v = 1'b1;
        end
    endtask

    task automatic model_check();
        logic [31:0] e_insn;
        logic [11:0] e_pcp;
        logic        e_v;
        model_out(e_insn, e_pcp, e_v);
        chk("model_insn", o_insn, e_insn);
        chk("model_pc_plus", o_PC_plus, e_pcp);
        chk("model_valid", o_valid, e_v);
        chk("model_imem_addr", o_imem_addr, m_pc);
    endtask

    task automatic model_step(input bit s, input bit r, input logic [11:0] t);
        logic [31:0] e_insn;
        logic [11:0] e_pcp;
        logic        e_v;
        logic [11:0] fetched;
        model_out(e_insn, e_pcp, e_v);
        fetched = m_pc;
        if (r) begin
            m_pc   = t;
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (!s) m_pc = m_pc + 12'd1;
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (!s) begin
                m_pc = m_pc + 12'd1;
            end else begin
                m_held_insn = e_insn;
                m_held_pcp  = e_pcp;
                m_mode      = 2;
            end
        end else begin
            if (!s) begin
                m_pc   = m_pc + 12'd1;
                m_mode = 1;
            end
        end
        m_inflight = fetched;
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, advance the model.
    task automatic cyc(input bit s, input bit r, input logic [11:0] t);
        @(negedge clock);
        i_stall           = s;
        i_redirect        = r;
        i_redirect_target = t;
        #1;
        model_check();
        model_step(s, r, t);
    endtask

    task automatic exp_out(input string tag, input logic [31:0] insn, input logic [11:0] pcp,
                           input logic v);
        chk({tag, "_insn"}, o_insn, insn);
        chk({tag, "_pc_plus"}, o_PC_plus, pcp);
        chk({tag, "_valid"}, o_valid, v);
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        bit          s, r;
        logic [11:0] t;

        for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
        model_reset();

        repeat (3) @(posedge clock);
        #1;
        exp_out("in_reset", 32'h0, 12'h0, 1'b0);
        chk("in_reset_addr", o_imem_addr, 12'h000);
        release_reset();

        // Reset release sequence.
        cyc(0, 0, 0);  exp_out("boot", 32'h0, 12'h0, 1'b0);
        chk("boot_addr", o_imem_addr, 12'h000);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0);
            exp_out("start", 32'h1000_0000 + i, 12'(i + 1), 1'b1);
        end

        // Three-cycle stall while mem[5] is shown.
        for (int i = 0; i < 4; i++) begin
            cyc((i < 3), 0, 0);
            exp_out("stall_hold", 32'h1000_0005, 12'h006, 1'b1);
            chk("stall_addr", o_imem_addr, 12'h006);
        end
        cyc(0, 0, 0);       exp_out("after_stall", 32'h1000_0006, 12'h007, 1'b1);

        // Redirect while mem[7] is shown.
        cyc(0, 1, 12'h040); exp_out("redir_cycle", 32'h1000_0007, 12'h008, 1'b1);
        cyc(0, 0, 0);       exp_out("squash", 32'h0, 12'h0, 1'b0);
        chk("squash_addr", o_imem_addr, 12'h040);
        cyc(0, 0, 0);       exp_out("target", 32'h1000_0040, 12'h041, 1'b1);

        // Redirect together with a stall while in HOLD.
        cyc(1, 0, 0);       exp_out("pre_hold", 32'h1000_0041, 12'h042, 1'b1);
        cyc(1, 1, 12'h020); exp_out("hold_redir", 32'h1000_0041, 12'h042, 1'b1);
        cyc(1, 0, 0);       exp_out("hold_squash", 32'h0, 12'h0, 1'b0);
        chk("hold_squash_addr", o_imem_addr, 12'h020);
        cyc(1, 0, 0);       exp_out("tgt20_a", 32'h1000_0020, 12'h021, 1'b1);
        cyc(1, 0, 0);       exp_out("tgt20_b", 32'h1000_0020, 12'h021, 1'b1);

        // Release together with a redirect to the top of the address space.
        cyc(0, 1, 12'hFFE); exp_out("tgt20_c", 32'h1000_0020, 12'h021, 1'b1);
        cyc(0, 0, 0);       exp_out("wrap_bubble", 32'h0, 12'h0, 1'b0);
        cyc(0, 0, 0);       exp_out("wrap_ffe", 32'h1000_0FFE, 12'hFFF, 1'b1);
        cyc(0, 0, 0);       exp_out("wrap_fff", 32'h1000_0FFF, 12'h000, 1'b1);
        cyc(0, 0, 0);       exp_out("wrap_000", 32'h1000_0000, 12'h001, 1'b1);

        // Async reset in the middle of a stall.
        cyc(1, 0, 0);       exp_out("rst_pre", 32'h1000_0001, 12'h002, 1'b1);
        cyc(1, 0, 0);       exp_out("rst_hold", 32'h1000_0001, 12'h002, 1'b1);
        #1 reset = 1'b0;
        #1;
        exp_out("async_rst", 32'h0, 12'h0, 1'b0);
        chk("async_rst_addr", o_imem_addr, 12'h000);
        model_reset();
        i_stall = 1'b0;
        release_reset();
        cyc(0, 0, 0);  exp_out("reboot", 32'h0, 12'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0);
            exp_out("restart", 32'h1000_0000 + i, 12'(i + 1), 1'b1);
        end

        // Randomized traffic against the model, with a randomized memory image.
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        for (int n = 0; n < 3000; n++) begin
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 15) == 0);
            t = ($urandom_range(0, 3) == 0) ? 12'(12'hFFC + $urandom_range(0, 3))
                                            : 12'($urandom_range(0, 4095));
            cyc(s, r, t);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
